// File: rtl/mem_pkg.sv
// mem_pkg: state encoding and default geometry shared by the burst memory model
package mem_pkg;
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_WAIT} mem_state_t;
  localparam int DEF_LINE_WORDS = 8;
  localparam int DEF_DELAY_BITS = 3;
  localparam int BEAT_BITS = $clog2(DEF_LINE_WORDS);
  localparam int LATENCY = 2 ** DEF_DELAY_BITS;
  function automatic int beat_bits(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction
endpackage

// File: rtl/burst_mem_array.sv
// burst_mem_array: single-port word RAM, synchronous write and registered read
module burst_mem_array
  import mem_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 14,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_din;
    o_dout <= r_mem[i_addr];
  end
endmodule

// File: rtl/burst_memory.sv
// burst_memory: line-burst main memory with 2**DELAY_BITS access latency
// BURST_WRAP_EN selects critical-word-first beat ordering.
module burst_memory
  import mem_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 14,
  parameter int    LINE_WORDS = 8,
  parameter int    DELAY_BITS = 3,
  parameter string INIT_FILE  = ""
) (
  input  logic                  MEM_CLK,
  input  logic                  RST,
  input  logic                  MEM_RDEN,
  input  logic                  MEM_WE,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [DATA_WIDTH-1:0] MEM_DIN,
  output logic [DATA_WIDTH-1:0] MEM_DOUT,
  output logic                  memValid,
  output logic                  memLast,
  output logic                  memBusy,
  output logic                  memDone
);
  localparam int LB = beat_bits(LINE_WORDS);
  localparam int LN = ADDR_WIDTH - LB;
`ifdef BURST_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  mem_state_t            r_state;
  logic [LN-1:0]         r_line;
  logic [LB-1:0]         r_idx;
  logic [LB-1:0]         r_beat;
  logic [DELAY_BITS-1:0] r_cnt;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_idle;
  logic                  w_we;
  logic [LB-1:0]         w_start;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_rdata;
  assign w_idle  = r_state == IDLE;
  assign w_start = WRAP ? MEM_ADDR[LB-1:0] : '0;
  // beat 0 of a write goes straight from the request inputs in the accept cycle
  assign w_addr  = w_idle ? {MEM_ADDR[ADDR_WIDTH-1:LB], w_start} : {r_line, r_idx};
  assign w_we    = !RST && (w_idle ? MEM_WE : r_state == WR_DATA);
  burst_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (MEM_CLK),
    .i_we  (w_we),
    .i_addr(w_addr),
    .i_din (MEM_DIN),
    .o_dout(w_rdata)
  );
  always_ff @(posedge MEM_CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_idx   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (MEM_WE || MEM_RDEN) begin
          r_state <= MEM_WE ? WR_DATA : RD_WAIT;
          r_line  <= MEM_ADDR[ADDR_WIDTH-1:LB];
          r_idx   <= MEM_WE ? w_start + 1'b1 : w_start;
          r_beat  <= MEM_WE ? LB'(1) : '0;
          r_cnt   <= '1;
          r_busy  <= 1'b1;
        end
        RD_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          // array read of beat 0 is issued one cycle ahead of its valid cycle
          if (r_cnt == DELAY_BITS'(1)) begin
            r_state <= RD_BURST;
            r_idx   <= r_idx + 1'b1;
            r_valid <= 1'b1;
          end
        end
        RD_BURST: begin
          r_idx  <= r_idx + 1'b1;
          r_beat <= r_beat + 1'b1;
          r_last <= r_beat == LB'(LINE_WORDS - 2);
          if (r_last) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        WR_DATA: begin
          r_idx  <= r_idx + 1'b1;
          r_beat <= r_beat + 1'b1;
          if (r_beat == LB'(LINE_WORDS - 1)) begin
            r_state <= WR_WAIT;
            r_cnt   <= '1;
          end
        end
        WR_WAIT: begin
          r_cnt  <= r_cnt - 1'b1;
          r_done <= r_cnt == DELAY_BITS'(1);
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign MEM_DOUT = r_valid ? w_rdata : '0;
  assign memValid = r_valid;
  assign memLast  = r_last;
  assign memBusy  = r_busy;
  assign memDone  = r_done;
endmodule

// File: tb/tb_burst_memory.sv
// tb_burst_memory: randomized line-burst traffic checked against a word-array model
module tb_burst_memory;
  localparam int DW  = 32;
  localparam int AW  = 14;
  localparam int LW  = 8;
  localparam int DB  = 3;
  localparam int LAT = 2 ** DB;
  logic          clk = 1'b0;
  logic          rst;
  logic          rden;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          valid;
  logic          last;
  logic          busy;
  logic          done;
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] model [int];
  logic [DW-1:0] d [LW];
  int            lines [9];
  always #5 clk = ~clk;
  burst_memory #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LINE_WORDS(LW),
    .DELAY_BITS(DB),
    .INIT_FILE ("")
  ) dut (
    .MEM_CLK (clk),
    .RST     (rst),
    .MEM_RDEN(rden),
    .MEM_WE  (we),
    .MEM_ADDR(addr),
    .MEM_DIN (din),
    .MEM_DOUT(dout),
    .memValid(valid),
    .memLast (last),
    .memBusy (busy),
    .memDone (done)
  );
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int start_of(input int a);
`ifdef BURST_WRAP_EN
    return a % LW;
`else
    return 0;
`endif
  endfunction
  function automatic int beat_addr(input int a, input int k);
    return (a / LW) * LW + (start_of(a) + k) % LW;
  endfunction
  task automatic do_read(input int a, input int poke);
    bit            v;
    logic [DW-1:0] exp;
    @(negedge clk);
    rden = 1'b1;
    we   = 1'b0;
    addr = AW'(a);
    for (int c = 1; c <= LAT + LW; c++) begin
      @(negedge clk);
      v   = c >= LAT && c < LAT + LW;
      exp = '0;
      if (v) exp = model[beat_addr(a, c - LAT)];
      check("rd_valid", valid, v);
      check("rd_data", dout, exp);
      check("rd_last", last, c == LAT + LW - 1);
      check("rd_busy", busy, c < LAT + LW);
      check("rd_done", done, 0);
      rden = c == poke;
      we   = c == poke && $urandom_range(0, 1) == 1;
      addr = AW'($urandom);
      din  = $urandom;
    end
    rden = 1'b0;
    we   = 1'b0;
  endtask
  task automatic do_write(input int a, input logic [DW-1:0] dat [LW], input bit both, input int poke);
    @(negedge clk);
    we   = 1'b1;
    rden = both;
    addr = AW'(a);
    din  = dat[0];
    for (int c = 1; c <= LAT + LW; c++) begin
      @(negedge clk);
      check("wr_done", done, c == LW - 1 + LAT);
      check("wr_busy", busy, c < LW + LAT);
      check("wr_valid", valid, 0);
      check("wr_dout", dout, 0);
      we   = c == poke;
      rden = c == poke;
      addr = AW'($urandom);
      din  = (c < LW) ? dat[c] : $urandom;
    end
    we   = 1'b0;
    rden = 1'b0;
    for (int k = 0; k < LW; k++) model[beat_addr(a, k)] = dat[k];
  endtask
  initial begin
    rst  = 1'b1;
    rden = 1'b0;
    we   = 1'b0;
    addr = '0;
    din  = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_last", last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dout", dout, 0);
    rst = 1'b0;
    for (int l = 0; l < 8; l++) begin
      for (int k = 0; k < LW; k++) d[k] = l * LW + k;
      do_write(l * LW, d, 0, 0);
      lines[l] = l * LW;
    end
    for (int k = 0; k < LW; k++) d[k] = 32'hF000 + k;
    do_write(14'h3FF8, d, 0, 0);
    lines[8] = 14'h3FF8;
    do_read(14'h10, 0);
    for (int k = 0; k < LW; k++) d[k] = 32'hA0 + k;
    do_write(14'h20, d, 0, 0);
    do_read(14'h20, 0);
    for (int k = 0; k < LW; k++) d[k] = 32'hB0 + k;
    do_write(14'h30, d, 1, 0);
    do_read(14'h30, 0);
    do_read(14'h10, 3);
    @(negedge clk);
    rden = 1'b1;
    addr = 14'h10;
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk);
      rden = 1'b0;
    end
    check("mid_beat3", dout, model[beat_addr(14'h10, 3)]);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", valid, 0);
    check("abort_last", last, 0);
    check("abort_busy", busy, 0);
    check("abort_dout", dout, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle", busy, 0);
    do_read(14'h10, 0);
    do_read(14'h15, 0);
    do_read(14'h3FFD, 0);
    repeat (40) begin
      int a;
      int poke;
      a    = lines[$urandom_range(0, 8)] + $urandom_range(0, LW - 1);
      poke = ($urandom_range(0, 1) == 1) ? $urandom_range(1, LAT + LW - 2) : 0;
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < LW; k++) d[k] = $urandom;
        do_write(a, d, $urandom_range(0, 1) == 1, poke);
      end else begin
        do_read(a, poke);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
